// File: rtl/pattern_scan_pkg.sv
// rtl/pattern_scan_pkg.sv - shared types, defaults and round-robin pick for the pattern scan arbiter
package pattern_scan_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REPORT
    } state_t;

    localparam int DEF_PAT_W = 6;
    localparam logic [DEF_PAT_W-1:0] DEF_PATTERN = 6'b101010;
    localparam int MAX_NREQ = 8;

    // First requesting index at or after ptr, wrapping within nreq.
    function automatic int rr_pick(input logic [MAX_NREQ-1:0] req, input int ptr, input int nreq);
        int win;
        int idx;
        logic found;
        win   = 0;
        found = 1'b0;
        for (int k = 0; k < nreq; k++) begin
            idx = (ptr + k) % nreq;
            if (!found && req[idx[2:0]]) begin
                win   = idx;
                found = 1'b1;
            end
        end
        return win;
    endfunction

endpackage

// File: rtl/pattern_detector.sv
// rtl/pattern_detector.sv - overlapping serial pattern detector with fill tracking
module pattern_detector
    import pattern_scan_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic valid,
    input  logic x,
    output logic z
);

    localparam int FW = $clog2(PAT_W + 1);

    logic [PAT_W-2:0] hist;
    logic [FW-1:0]    fill;
    logic [PAT_W-1:0] window;

    // Only PAT_W-1 older bits are kept; the current bit completes the window.
    assign window = {hist, x};
    assign z      = valid && (fill >= FW'(PAT_W - 1)) && (window == PATTERN);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            hist <= '0;
            fill <= '0;
        end else if (clear) begin
            hist <= '0;
            fill <= '0;
        end else if (valid) begin
            hist <= window[PAT_W-2:0];
            if (fill != FW'(PAT_W))
                fill <= fill + 1'b1;
        end
    end

endmodule

// File: rtl/pattern_scan_arbiter.sv
// rtl/pattern_scan_arbiter.sv - round-robin word scanner sharing one serial pattern detector
module pattern_scan_arbiter
    import pattern_scan_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int WORD_W = 16,
    parameter int PAT_W = DEF_PAT_W,
    parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
    localparam int CNT_W = $clog2(WORD_W + 1),
    localparam int ID_W = $clog2(NREQ)
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NREQ-1:0]          req,
    input  logic [NREQ*WORD_W-1:0]   word_data,
    output logic [NREQ-1:0]          gnt,
    output logic                     busy,
    output logic                     done,
    output logic [ID_W-1:0]          done_id,
    output logic [CNT_W-1:0]         match_count,
    output logic                     match_any
);

    localparam int BIT_W = $clog2(WORD_W);

    state_t            state, state_next;
    logic [ID_W-1:0]   rr_ptr;
    logic [ID_W-1:0]   winner;
    logic [ID_W-1:0]   cur_id;
    logic [WORD_W-1:0] shreg;
    logic [BIT_W-1:0]  bit_idx;
    logic [CNT_W-1:0]  acc;
    logic              grant;
    logic              z;

    assign winner = ID_W'(rr_pick(MAX_NREQ'(req), int'(rr_ptr), NREQ));

    always_comb begin
        state_next = state;
        grant      = 1'b0;
        gnt        = '0;
        busy       = 1'b1;
        done       = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if ((|req) && !reset) begin
                    grant       = 1'b1;
                    gnt[winner] = 1'b1;
                    busy        = 1'b1;
                    state_next  = SHIFT;
                end
            end
            SHIFT: begin
                if (bit_idx == '0)
                    state_next = REPORT;
            end
            REPORT: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_next;
    end

    // Results are registered on the last SHIFT edge so they are valid alongside done.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rr_ptr      <= '0;
            cur_id      <= '0;
            shreg       <= '0;
            bit_idx     <= '0;
            acc         <= '0;
            done_id     <= '0;
            match_count <= '0;
            match_any   <= 1'b0;
        end else begin
            if (grant) begin
                shreg   <= word_data[int'(winner)*WORD_W +: WORD_W];
                cur_id  <= winner;
                bit_idx <= BIT_W'(WORD_W - 1);
                acc     <= '0;
                rr_ptr  <= (winner == ID_W'(NREQ - 1)) ? '0 : winner + 1'b1;
            end
            if (state == SHIFT) begin
                shreg   <= {shreg[WORD_W-2:0], 1'b0};
                bit_idx <= bit_idx - 1'b1;
                acc     <= acc + CNT_W'(z);
                if (bit_idx == '0) begin
                    match_count <= acc + CNT_W'(z);
                    match_any   <= (acc != '0) || z;
                    done_id     <= cur_id;
                end
            end
        end
    end

    pattern_detector #(
        .PAT_W   (PAT_W),
        .PATTERN (PATTERN)
    ) u_detector (
        .clock (clock),
        .reset (reset),
        .clear (grant),
        .valid (state == SHIFT),
        .x     (shreg[WORD_W-1]),
        .z     (z)
    );

endmodule

// File: tb/tb_pattern_scan_arbiter.sv
// tb/tb_pattern_scan_arbiter.sv - self-checking bench for pattern_scan_arbiter
module tb_pattern_scan_arbiter;

    localparam int NREQ   = 4;
    localparam int WORD_W = 16;
    localparam int PAT_W  = 6;
    localparam int CNT_W  = 5;
    localparam int ID_W   = 2;
    localparam logic [PAT_W-1:0] PAT = 6'b101010;

    logic                   clock = 1'b0;
    logic                   reset = 1'b1;
    logic [NREQ-1:0]        req = '0;
    logic [NREQ*WORD_W-1:0] word_data = '1;
    logic [NREQ-1:0]        gnt;
    logic                   busy;
    logic                   done;
    logic [ID_W-1:0]        done_id;
    logic [CNT_W-1:0]       match_count;
    logic                   match_any;

    pattern_scan_arbiter dut (
        .clock       (clock),
        .reset       (reset),
        .req         (req),
        .word_data   (word_data),
        .gnt         (gnt),
        .busy        (busy),
        .done        (done),
        .done_id     (done_id),
        .match_count (match_count),
        .match_any   (match_any)
    );

    always #5 clock = ~clock;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Count every window start position whose PAT_W bits equal the pattern.
    function automatic int ref_count(input logic [WORD_W-1:0] w);
        int n;
        logic [PAT_W-1:0] win;
        n = 0;
        for (int s = 0; s <= WORD_W - PAT_W; s++) begin
            win = w[WORD_W-1-s -: PAT_W];
            if (win == PAT) n++;
        end
        return n;
    endfunction

    function automatic logic [WORD_W-1:0] word_of(input int i);
        return word_data[i*WORD_W +: WORD_W];
    endfunction

    // Transaction-level model: a scan occupies WORD_W+2 cycles from its grant.
    int m_ptr = 0, m_busy = 0, m_done_cyc = 0;
    int m_pend_id = 0, m_pend_cnt = 0, m_id = 0, m_cnt = 0;
    int exp_gnt, exp_done, w;

    always @(negedge clock) begin
        if (reset) begin
            m_ptr = 0; m_busy = 0; m_id = 0; m_cnt = 0;
            check("rst_gnt", gnt, 0);
            check("rst_busy", busy, 0);
            check("rst_done", done, 0);
            check("rst_done_id", done_id, 0);
            check("rst_match_count", match_count, 0);
            check("rst_match_any", match_any, 0);
        end else begin
            exp_gnt = 0;
            exp_done = 0;
            if (m_busy != 0 && cyc == m_done_cyc) begin
                exp_done = 1;
                m_id = m_pend_id;
                m_cnt = m_pend_cnt;
            end else if (m_busy == 0 && req != 0) begin
                w = -1;
                for (int k = 0; k < NREQ; k++)
                    if (w < 0 && req[(m_ptr + k) % NREQ]) w = (m_ptr + k) % NREQ;
                exp_gnt = 1 << w;
                m_pend_id = w;
                m_pend_cnt = ref_count(word_of(w));
                m_done_cyc = cyc + WORD_W + 1;
                m_ptr = (w + 1) % NREQ;
                m_busy = 1;
            end
            check("gnt", gnt, exp_gnt);
            check("busy", busy, m_busy);
            check("done", done, exp_done);
            check("done_id", done_id, m_id);
            check("match_count", match_count, m_cnt);
            check("match_any", match_any, (m_cnt != 0) ? 1 : 0);
            if (exp_done != 0) m_busy = 0;
        end
    end

    task automatic drive_req(input logic [NREQ-1:0] r);
        @(posedge clock);
        #1 req = r;
    endtask

    task automatic set_word(input int i, input logic [WORD_W-1:0] v);
        word_data[i*WORD_W +: WORD_W] = v;
    endtask

    task automatic wait_gnt(output int id, output int at);
        id = -1;
        at = -1;
        for (int n = 0; n < 60 && id < 0; n++) begin
            @(negedge clock);
            if (gnt != 0) begin
                at = cyc;
                for (int i = 0; i < NREQ; i++) if (gnt[i]) id = i;
            end
        end
        if (id < 0) check("gnt_timeout", 0, 1);
    endtask

    task automatic wait_done(output int id, output int cnt, output int any, output int at);
        id = -1; cnt = -1; any = -1; at = -1;
        for (int n = 0; n < 60 && at < 0; n++) begin
            @(negedge clock);
            if (done) begin
                at = cyc; id = done_id; cnt = match_count; any = match_any;
            end
        end
        if (at < 0) check("done_timeout", 0, 1);
    endtask

    task automatic pulse_reset();
        @(posedge clock);
        #1 reset = 1'b1;
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
    endtask

    int gid, gat, did, dcnt, dany, dat, prev_gat, n_done, n_gnt3, n_done3;
    int order[4] = '{0, 1, 3, 0};

    initial begin
        // Literal pins on the reference counter itself.
        check("model_aaaa", ref_count(16'hAAAA), 6);
        check("model_5555", ref_count(16'h5555), 5);
        check("model_002a", ref_count(16'h002A), 1);

        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        // 1: single requester, alternating word
        set_word(0, 16'hAAAA);
        drive_req(4'b0001);
        wait_gnt(gid, gat);
        check("t1_gnt_id", gid, 0);
        drive_req(4'b0000);
        wait_done(did, dcnt, dany, dat);
        check("t1_latency", dat - gat, 17);
        check("t1_done_id", did, 0);
        check("t1_count", dcnt, 6);
        check("t1_any", dany, 1);

        // 2: requester 1, then an all-zero word
        set_word(1, 16'h5555);
        drive_req(4'b0010);
        wait_gnt(gid, gat);
        drive_req(4'b0000);
        wait_done(did, dcnt, dany, dat);
        check("t2a_done_id", did, 1);
        check("t2a_count", dcnt, 5);
        set_word(1, 16'h0000);
        drive_req(4'b0010);
        wait_gnt(gid, gat);
        drive_req(4'b0000);
        wait_done(did, dcnt, dany, dat);
        check("t2b_count", dcnt, 0);
        check("t2b_any", dany, 0);

        // 3: simultaneous held requests rotate 0,1,3,0 every WORD_W+2 cycles
        pulse_reset();
        for (int i = 0; i < NREQ; i++) set_word(i, 16'h002A);
        drive_req(4'b1011);
        prev_gat = 0;
        for (int k = 0; k < 4; k++) begin
            wait_gnt(gid, gat);
            check("t3_order", gid, order[k]);
            if (k > 0) check("t3_spacing", gat - prev_gat, 18);
            prev_gat = gat;
            wait_done(did, dcnt, dany, dat);
            check("t3_count", dcnt, 1);
        end
        drive_req(4'b0000);
        word_data = '1;

        // 5: reset five cycles into SHIFT aborts the scan
        set_word(0, 16'hAAAA);
        drive_req(4'b0001);
        wait_gnt(gid, gat);
        drive_req(4'b0000);
        repeat (4) @(posedge clock);
        #1 reset = 1'b1;
        #1 check("t5_busy_async", busy, 0);
        check("t5_count_async", match_count, 0);
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        n_done = 0;
        repeat (20) begin
            @(negedge clock);
            if (done) n_done++;
        end
        check("t5_no_done", n_done, 0);
        set_word(2, 16'hA800);
        drive_req(4'b0100);
        wait_gnt(gid, gat);
        check("t5_gnt_id", gid, 2);
        drive_req(4'b0000);
        wait_done(did, dcnt, dany, dat);
        check("t5_done_id", did, 2);
        check("t5_count", dcnt, 1);

        // 4: back-to-back words from one requester do not share history
        set_word(0, 16'h0015);
        drive_req(4'b0001);
        wait_gnt(gid, gat);
        @(posedge clock);
        #1 set_word(0, 16'h4000);
        wait_done(did, dcnt, dany, dat);
        check("t4a_count", dcnt, 0);
        wait_gnt(gid, gat);
        check("t4_back_to_back", gat - dat, 1);
        drive_req(4'b0000);
        wait_done(did, dcnt, dany, dat);
        check("t4b_count", dcnt, 0);

        // 6: request from 3 raised and withdrawn while busy is never served
        set_word(0, 16'hAAAA);
        set_word(3, 16'hAAAA);
        drive_req(4'b0001);
        wait_gnt(gid, gat);
        drive_req(4'b1000);
        repeat (5) @(posedge clock);
        #1 req = 4'b0000;
        n_gnt3 = 0; n_done3 = 0; n_done = 0;
        repeat (40) begin
            @(negedge clock);
            if (gnt[3]) n_gnt3++;
            if (done) begin
                n_done++;
                if (done_id == 2'd3) n_done3++;
            end
        end
        check("t6_no_gnt3", n_gnt3, 0);
        check("t6_no_done3", n_done3, 0);
        check("t6_one_done", n_done, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

// File: doc/pattern_scan_arbiter.md
Name: pattern_scan_arbiter

Overview:
Shares one serial pattern detector (default pattern 101010, overlapping) among NREQ requesters. Each requester presents a parallel word. The block grants requesters round-robin, serializes the granted word MSB-first into the detector, and counts matches. It then reports a per-word match count tagged with the requester id. It sits between the word producers and the bit-serial detection datapath.

Parameters:
NREQ, 4, number of requesters (2..8)
WORD_W, 16, bits per scanned word
PAT_W, 6, pattern length (2..WORD_W)
PATTERN, 6'b101010, pattern to match; MSB is the first bit received
CNT_W, localparam, $clog2(WORD_W+1), width of the match count
ID_W, localparam, $clog2(NREQ), width of the requester id

Ports:
clock  in  1  rising-edge clock
reset  in  1  asynchronous, active-high; clears all state
req  in  NREQ  per-requester request level; held until gnt
word_data  in  NREQ*WORD_W  requester i word at [i*WORD_W +: WORD_W]
gnt  out  NREQ  one-hot, one-cycle pulse; word captured
busy  out  1  high from gnt cycle through done cycle
done  out  1  one-cycle pulse; result valid
done_id  out  ID_W  requester id of the completed scan; held until next done
match_count  out  CNT_W  overlapping matches in the word; held until next done
match_any  out  1  match_count != 0; held with match_count

Behaviour:
- Reset values: gnt=0, busy=0, done=0, done_id=0, match_count=0, match_any=0. FSM=IDLE, rr pointer=0, detector history cleared.
- FSM states: IDLE, SHIFT, REPORT.
- IDLE:
  - req sampled only here.
  - If req!=0, arbitrate round-robin starting at the rr pointer.
  - At the clock edge: latch the winner's word and id, pulse gnt[winner] for one cycle, set busy, and clear the detector history, fill counter and match accumulator. Go to SHIFT with bit index WORD_W-1.
  - rr pointer becomes (winner+1) mod NREQ.
- SHIFT, one bit per cycle, MSB first:
  - The detector shift register shifts the bit in.
  - z is asserted combinationally when the fill count (including the current bit) is >= PAT_W and the last PAT_W bits equal PATTERN.
  - The accumulator increments on z.
  - After bit 0 is fed, go to REPORT.
  - SHIFT lasts exactly WORD_W cycles.
- REPORT:
  - done=1 for one cycle; match_count, match_any and done_id update on this edge.
  - busy deasserts after this cycle. Return to IDLE.
  - A new grant can occur no earlier than the cycle after REPORT.
- Latency: gnt in cycle T, first bit in T+1, done in T+WORD_W+1. Back-to-back grant period is WORD_W+2 cycles.
- Matches never span words; history is cleared at each grant. Overlapping matches all count.
- Max count is WORD_W-PAT_W+1, so there is no saturation logic.
- Boundary conditions:
  - req asserted while busy: waits, no gnt.
  - req dropped before gnt: not served.
  - Simultaneous reqs: the requester nearest the rr pointer (ascending, wrapping) wins.
  - Only one requester active: served repeatedly.
  - word_data of non-granted requesters is ignored.
  - Reset mid-SHIFT or mid-REPORT: immediate return to IDLE, outputs to reset values, no done, rr pointer=0.
  - X on word_data of a non-requesting input must not propagate.

Decomposition:
- Shared package pattern_scan_pkg:
  - state enum (IDLE/SHIFT/REPORT)
  - default PATTERN/PAT_W constants
  - function computing the rr winner from req and the pointer
- One sub-module: pattern_detector.
  - Ports: clock, reset, clear, valid, x, z.
  - Parameterized PAT_W/PATTERN.
  - Holds the shift register and fill counter; reusable as the standalone serial detector.

Test Plan:
1. Reset, then req=4'b0001, word0=16'hAAAA -> gnt=0001 at T, done at T+17, done_id=0, match_count=6, match_any=1.
2. req=4'b0010, word1=16'h5555 -> match_count=5, done_id=1; word1=16'h0000 -> match_count=0, match_any=0.
3. Fresh reset, req=4'b1011 held (words 16'h002A each) -> grant order 0,1,3,0. Each done reports match_count=1. Grants are spaced 18 cycles.
4. Cross-word isolation: word0=16'h0015 then word1=16'h4000 (same requester, consecutive) -> both report 0. No match across the word boundary.
5. Assert reset 5 cycles into SHIFT -> busy=0 asynchronously, no done pulse, match_count=0. The next req=4'b0100 is granted to requester 2 with correct count.
6. req raised while busy for requester 3, then dropped before IDLE -> no gnt[3], no done for id 3.
